alu_word_seq: RTL and testbench

- Sequencer that runs NBYTES-wide operations on the 8-bit ALU by issuing one byte slice per cycle and chaining the carry between slices.
- Sits between the instruction/control logic (request side) and a single 8-bit ALU instance (ALU-side ports). The ALU is combinational and external to this block.
- Accepts a word-wide request and returns a word-wide result, both with valid/ready handshakes.

---
 rtl/alu_word_seq_if.sv | 43 ++++
 rtl/alu_word_seq.sv | 127 ++++++++++++
 tb/tb_alu_word_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_word_seq_if.sv
// Request, response and ALU-side signal bundle for the multi-byte ALU sequencer.
// The sequencer uses the slave view; the surrounding logic and the ALU use the master view.
interface alu_word_seq_if #(
    parameter int NBYTES = 4
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [8*NBYTES-1:0]   req_a;
    logic [8*NBYTES-1:0]   req_b;
    logic [3:0]            req_op;
    logic                  req_cin;
    logic                  req_msb_first;

    logic [7:0]            alu_a;
    logic [7:0]            alu_b;
    logic [3:0]            alu_op;
    logic                  alu_cin;
    logic [7:0]            alu_q;
    logic                  alu_cout;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8*NBYTES-1:0]   rsp_q;
    logic                  rsp_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_cin, req_msb_first,
        output req_ready,
        output alu_a, alu_b, alu_op, alu_cin,
        input  alu_q, alu_cout,
        output rsp_valid, rsp_q, rsp_cout,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_op, req_cin, req_msb_first,
        input  req_ready,
        input  alu_a, alu_b, alu_op, alu_cin,
        output alu_q, alu_cout,
        input  rsp_valid, rsp_q, rsp_cout,
        output rsp_ready
    );
endinterface

// File: rtl/alu_word_seq.sv
// Runs NBYTES-wide operations on an external 8-bit combinational ALU, one byte
// slice per cycle, chaining the carry from each slice into the next.
module alu_word_seq #(
    parameter int NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_word_seq_if.slave bus,
    output logic          busy
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [IW-1:0]          idx_r;
    logic [IW-1:0]          pos_s;
    logic [NBYTES-1:0][7:0] a_r;
    logic [NBYTES-1:0][7:0] b_r;
    logic [NBYTES-1:0][7:0] q_r;
    logic [3:0]             op_r;
    logic                   cin_r;
    logic                   msb_r;
    logic                   carry_r;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) state_s = ST_RUN;
                else               state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) state_s = ST_DONE;
                else                   state_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.rsp_ready) state_s = ST_IDLE;
                else               state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Slice addressing and ALU drive, derived from registered state only
    always_comb begin
        pos_s       = msb_r ? (LAST_IDX - idx_r) : idx_r;
        bus.alu_a   = 8'h00;
        bus.alu_b   = 8'h00;
        bus.alu_op  = 4'h0;
        bus.alu_cin = 1'b0;
        if (state_r == ST_RUN) begin
            bus.alu_a = a_r[pos_s];
            bus.alu_b = b_r[pos_s];
            if (idx_r == {IW{1'b0}}) begin
                bus.alu_op  = op_r;
                bus.alu_cin = cin_r;
            end else begin
                // Later add/sub slices switch to the with-carry variant of the op
                bus.alu_op  = (op_r[3:2] == 2'b00) ? {op_r[3:1], 1'b1} : op_r;
                bus.alu_cin = carry_r;
            end
        end else begin
            bus.alu_a   = 8'h00;
            bus.alu_b   = 8'h00;
            bus.alu_op  = 4'h0;
            bus.alu_cin = 1'b0;
        end
    end

    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.rsp_valid = (state_r == ST_DONE);
    assign busy          = (state_r == ST_RUN) || (state_r == ST_DONE);
    assign bus.rsp_q     = q_r;
    assign bus.rsp_cout  = carry_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Operand capture, slice index, carry chain and result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {(8*NBYTES){1'b0}};
            b_r     <= {(8*NBYTES){1'b0}};
            q_r     <= {(8*NBYTES){1'b0}};
            op_r    <= 4'h0;
            cin_r   <= 1'b0;
            msb_r   <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= {IW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        a_r   <= bus.req_a;
                        b_r   <= bus.req_b;
                        op_r  <= bus.req_op;
                        cin_r <= bus.req_cin;
                        msb_r <= bus.req_msb_first;
                        idx_r <= {IW{1'b0}};
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_RUN: begin
                    q_r[pos_s] <= bus.alu_q;
                    carry_r    <= bus.alu_cout;
                    if (idx_r != LAST_IDX) idx_r <= idx_r + IW'(1);
                    else                   idx_r <= idx_r;
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_word_seq.sv
// Randomized and directed bench for alu_word_seq with a behavioural 8-bit ALU
// attached; covers NBYTES=4 and an NBYTES=1 instance side by side.
module tb_alu_word_seq;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic busy1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_word_seq_if #(.NBYTES(NB)) bus ();
    alu_word_seq_if #(.NBYTES(1))  bus1 ();

    alu_word_seq #(.NBYTES(NB)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus),  .busy(busy));
    alu_word_seq #(.NBYTES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

    // Bench ALU: returns {cout, q}
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op, input logic cin);
        logic [8:0] r;
        case (op)
            4'b0000: r = {1'b0, a} + {1'b0, b};
            4'b0001: r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'b0010: r = {1'b0, a} + {1'b0, ~b} + 9'd1;
            4'b0011: r = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
            4'b0100: r = {cin, a & b};
            4'b0101: r = {cin, a | b};
            4'b0110: r = {cin, a ^ b};
            4'b0111: r = {cin, ~a};
            4'b1000: r = {a[7], a[6:0], cin};
            4'b1001: r = {a[0], cin, a[7:1]};
            default: r = {cin, a};
        endcase
        return r;
    endfunction

    always_comb {bus.alu_cout, bus.alu_q}   = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin);
    always_comb {bus1.alu_cout, bus1.alu_q} = alu_fn(bus1.alu_a, bus1.alu_b, bus1.alu_op, bus1.alu_cin);

    logic [7:0]      exp_a   [NB];
    logic [7:0]      exp_b   [NB];
    logic [3:0]      exp_op  [NB];
    logic            exp_cin [NB];
    logic [8*NB-1:0] exp_q;
    logic            exp_cout;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: walk byte positions in issue order, chaining carry through the bench ALU
    task automatic model(input logic [8*NB-1:0] a, input logic [8*NB-1:0] b,
                         input logic [3:0] op, input logic cin, input logic msb);
        logic       c;
        logic [8:0] r;
        int         p;
        c     = cin;
        exp_q = '0;
        for (int k = 0; k < NB; k++) begin
            p          = msb ? (NB - 1 - k) : k;
            exp_a[k]   = a[p*8 +: 8];
            exp_b[k]   = b[p*8 +: 8];
            exp_op[k]  = (k > 0 && op[3:2] == 2'b00) ? (op | 4'b0001) : op;
            exp_cin[k] = c;
            r          = alu_fn(exp_a[k], exp_b[k], exp_op[k], c);
            exp_q[p*8 +: 8] = r[7:0];
            c          = r[8];
        end
        exp_cout = c;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_flags"}, {61'd0, busy, bus.req_ready, bus.rsp_valid}, 64'b010);
        check({tag, "_rsp_q"}, bus.rsp_q, 64'd0);
        check({tag, "_cout"}, bus.rsp_cout, 64'd0);
        check({tag, "_alu"}, {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}, 64'd0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", {63'd0, bus.req_ready}, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic cin, input logic msb, input int hold, input int rst_at);
        @(negedge clk);
        wait_idle();
        model(a, b, op, cin, msb);
        bus.req_a = a; bus.req_b = b; bus.req_op = op;
        bus.req_cin = cin; bus.req_msb_first = msb; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a = $urandom(); bus.req_b = $urandom(); bus.req_op = 4'($urandom());
        bus.req_cin = 1'($urandom()); bus.req_msb_first = 1'($urandom());
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            check("run_flags", {61'd0, busy, bus.req_ready, bus.rsp_valid}, 64'b100);
            check("alu_a", bus.alu_a, exp_a[k]);
            check("alu_b", bus.alu_b, exp_b[k]);
            check("alu_op", bus.alu_op, exp_op[k]);
            check("alu_cin", bus.alu_cin, exp_cin[k]);
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_vals("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        check("done_flags", {61'd0, busy, bus.req_ready, bus.rsp_valid}, 64'b101);
        check("rsp_q", bus.rsp_q, exp_q);
        check("rsp_cout", bus.rsp_cout, exp_cout);
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = (h == 0);
            @(negedge clk);
            check("hold_flags", {61'd0, busy, bus.req_ready, bus.rsp_valid}, 64'b101);
            check("hold_q", bus.rsp_q, exp_q);
            check("hold_cout", bus.rsp_cout, exp_cout);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_hs_flags", {61'd0, busy, bus.req_ready, bus.rsp_valid}, 64'b010);
        check("post_hs_q", bus.rsp_q, exp_q);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = 4'h0;
        bus.req_cin = 1'b0; bus.req_msb_first = 1'b0; bus.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = 4'h0;
        bus1.req_cin = 1'b0; bus1.req_msb_first = 1'b0; bus1.rsp_ready = 1'b0;
        #12;
        check_reset_vals("reset");
        check("reset_n1", {61'd0, busy1, bus1.req_ready, bus1.rsp_valid}, 64'b010);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry ripple across three bytes
        run_op(32'h00FF_FFFF, 32'h0000_0001, 4'b0000, 1'b0, 1'b0, 0, -1);
        check("ripple_q", bus.rsp_q, 64'h0100_0000);
        check("ripple_cout", bus.rsp_cout, 64'd0);

        // Bitwise AND, issued top byte first
        run_op(32'h1122_3344, 32'h0F0F_0F0F, 4'b0100, 1'b0, 1'b1, 0, -1);
        check("and_q", bus.rsp_q, 64'h0102_0304);

        // Subtract with carry-in meaning no borrow: 0 - 1
        run_op(32'h0000_0000, 32'h0000_0001, 4'b0011, 1'b1, 1'b0, 0, -1);
        check("sub_q", bus.rsp_q, 64'hFFFF_FFFF);
        check("sub_cout", bus.rsp_cout, 64'd0);

        // Back-pressure for five cycles with a stray request
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 4'b0001, 1'b1, 1'b0, 5, -1);
        check("bp_sum", bus.rsp_q, 64'hF0E2_1568);

        // Asynchronous reset in slice 2, then a clean operation
        run_op(32'hCAFE_F00D, 32'h0101_0101, 4'b0000, 1'b0, 1'b0, 0, 2);
        run_op(32'h8000_0001, 32'h8000_0001, 4'b0000, 1'b0, 1'b0, 1, -1);
        check("post_rst_q", bus.rsp_q, 64'h0000_0002);
        check("post_rst_cout", bus.rsp_cout, 64'd1);

        for (int i = 0; i < 40; i++) begin
            run_op($urandom(), $urandom(), 4'($urandom()), 1'($urandom()), 1'($urandom()),
                   int'($urandom_range(0, 3)), -1);
        end

        // Single-byte instance: one RUN cycle, op never modified
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a8, b8;
            logic [3:0] op8;
            logic       c8;
            logic [8:0] r8;
            a8 = 8'($urandom()); b8 = 8'($urandom());
            op8 = 4'($urandom_range(0, 3)); c8 = 1'($urandom());
            r8 = alu_fn(a8, b8, op8, c8);
            @(negedge clk);
            bus1.req_a = a8; bus1.req_b = b8; bus1.req_op = op8; bus1.req_cin = c8;
            bus1.req_msb_first = 1'($urandom()); bus1.req_valid = 1'b1;
            @(posedge clk);
            #1 bus1.req_valid = 1'b0;
            @(negedge clk);
            check("n1_run", {62'd0, busy1, bus1.rsp_valid}, 64'b10);
            check("n1_alu_op", {bus1.alu_op, bus1.alu_cin}, {59'd0, op8, c8});
            @(negedge clk);
            check("n1_done", {62'd0, busy1, bus1.rsp_valid}, 64'b11);
            check("n1_q", {bus1.rsp_cout, bus1.rsp_q}, {55'd0, r8});
            bus1.rsp_ready = 1'b1;
            @(negedge clk);
            bus1.rsp_ready = 1'b0;
            check("n1_idle", {63'd0, bus1.req_ready}, 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
